// File: rtl/sram_wait_model.sv
// Cycle-accurate off-chip SRAM model for the MEM stage: fixed wait states,
// byte-lane writes, split read/write buses and a zero-fill sweep after reset.
module sram_wait_model #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 18,
   parameter int DEPTH  = 128,
   parameter int WAIT   = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_i,
   input  logic                       we_i,
   input  logic [DATA_W/8-1:0]        be_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic [DATA_W-1:0]          rdata_o,
   output logic                       ready_o,
   output logic                       init_done_o
);

   localparam int          BE_W   = DATA_W / 8;
   localparam int          CW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
   localparam logic [3:0]  WAIT_L = 4'(WAIT);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_DONE} state_e;

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic [3:0]          wcnt_q;
   logic                we_q;
   logic [BE_W-1:0]     be_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                ready_q;
   logic                init_done_q;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   // Fields of the access being completed on this edge. With WAIT = 0 the
   // acceptance edge is also the completion edge, so the live inputs are used.
   logic                acc_we;
   logic [BE_W-1:0]     acc_be;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic                commit;
   logic                acc_inr;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   wr_word;

   // Select completing-access fields and detect the edge that enters DONE
   always_comb begin
      acc_we    = we_q;
      acc_be    = be_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      commit    = 1'b0;
      if (state_q == S_IDLE) begin
         acc_we    = we_i;
         acc_be    = be_i;
         acc_addr  = addr_i;
         acc_wdata = wdata_i;
         commit    = req_i && (WAIT == 0);
      end else if (state_q == S_WAIT) begin
         commit = (wcnt_q == 4'd1);
      end
   end

   // Range check over the full address width (no aliasing of high bits)
   assign acc_inr = ({1'b0, acc_addr} < (ADDR_W+1)'(DEPTH));
   assign rd_word = acc_inr ? mem_q[acc_addr[CW-1:0]] : '0;

   // Merge enabled byte lanes of write data over the current word
   always_comb begin
      wr_word = rd_word;
      for (int i = 0; i < BE_W; i++) begin
         if (acc_be[i]) wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
      end
   end

   // Storage: zero-fill during the sweep, commit writes on entry to DONE
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (state_q == S_INIT) begin
            mem_q[cnt_q] <= '0;
         end else if (commit && acc_we && acc_inr) begin
            mem_q[acc_addr[CW-1:0]] <= wr_word;
         end
      end
   end

   // Access sequencer with registered ready/rdata/init_done
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (commit) begin
            ready_q <= 1'b1;
            if (!acc_we) rdata_q <= rd_word;
         end
         case (state_q)
            S_INIT: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_q     <= S_IDLE;
                  init_done_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  be_q    <= be_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  wcnt_q  <= WAIT_L;
                  state_q <= (WAIT == 0) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               wcnt_q <= wcnt_q - 4'd1;
               if (wcnt_q == 4'd1) state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign rdata_o     = rdata_q;
   assign ready_o     = ready_q;
   assign init_done_o = init_done_q;

endmodule
